// File: rtl/gf2m_sqr_regbank_pkg.sv
// Shared constants, FSM state type and trinomial reduction for the GF(2^M) squarer bank.
// Optional build macro GF2M_SQR_ACC_EN is handled in the interface and top files.
package ecc_gf2m_pkg;

    localparam int M      = 233;
    localparam int POLY_K = 74;
    localparam int NREG   = 4;
    localparam int CW     = 8;
    localparam int SW     = 2 * M - 1;
    localparam int IW     = $clog2(SW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WRITE
    } state_t;

    // Folds from the top bit down so x^i = x^(i-m+k) + x^(i-m) settles in one pass.
    function automatic logic [M-1:0] gf2m_reduce(
        input logic [SW-1:0] c,
        input int            m,
        input int            k
    );
        logic [SW-1:0] t;
        t = c;
        for (int i = SW - 1; i > 0; i--) begin
            if (i >= m && t[IW'(i)]) begin
                t[IW'(i)]         = 1'b0;
                t[IW'(i - m + k)] = ~t[IW'(i - m + k)];
                t[IW'(i - m)]     = ~t[IW'(i - m)];
            end
        end
        return t[M-1:0];
    endfunction

endpackage

// File: rtl/gf2m_sqr_regbank_if.sv
// Request/response bundle of the GF(2^M) squarer register bank.
// GF2M_SQR_ACC_EN adds the acc request bit.
interface gf2m_sqr_regbank_if #(
    parameter int M    = 233,
    parameter int NREG = 4,
    parameter int CW   = 8,
    parameter int DW   = (NREG > 1) ? $clog2(NREG) : 1
);
    logic              start;
    logic              ready;
    logic              src_sel;
    logic [M-1:0]      A;
    logic [M-1:0]      B;
    logic [CW-1:0]     sqr_cnt;
    logic [DW-1:0]     dst;
    logic              done;
    logic              err;
    logic [NREG*M-1:0] regs_q;
`ifdef GF2M_SQR_ACC_EN
    logic              acc;

    modport master (
        output start, src_sel, A, B, sqr_cnt, dst, acc,
        input  ready, done, err, regs_q
    );
    modport slave (
        input  start, src_sel, A, B, sqr_cnt, dst, acc,
        output ready, done, err, regs_q
    );
`else
    modport master (
        output start, src_sel, A, B, sqr_cnt, dst,
        input  ready, done, err, regs_q
    );
    modport slave (
        input  start, src_sel, A, B, sqr_cnt, dst,
        output ready, done, err, regs_q
    );
`endif
endinterface

// File: rtl/gf2m_sqr_regbank_square.sv
// Combinational squaring in GF(2^M) modulo x^M + x^POLY_K + 1.
module gf2m_square_trinomial #(
    parameter int M      = ecc_gf2m_pkg::M,
    parameter int POLY_K = ecc_gf2m_pkg::POLY_K
) (
    input  logic [M-1:0] DIN,
    output logic [M-1:0] DOUT
);
    import ecc_gf2m_pkg::*;

    logic [2*M-2:0]              w_spread;
    logic [SW-1:0]               w_wide;
    logic [ecc_gf2m_pkg::M-1:0]  w_red;

    for (genvar g = 0; g < M; g++) begin : g_sp
        assign w_spread[2*g] = DIN[g];
        if (g < M - 1) begin : g_z
            assign w_spread[2*g+1] = 1'b0;
        end
    end

    assign w_wide = SW'(w_spread);
    assign w_red  = gf2m_reduce(w_wide, M, POLY_K);
    assign DOUT   = w_red[M-1:0];

endmodule

// File: rtl/gf2m_sqr_regbank.sv
// Operand router: picks A/B, squares it sqr_cnt times, writes one of NREG registers.
// Build with GF2M_SQR_ACC_EN for an XOR-accumulate write mode.
module gf2m_sqr_regbank #(
    parameter int M      = ecc_gf2m_pkg::M,
    parameter int POLY_K = ecc_gf2m_pkg::POLY_K,
    parameter int NREG   = ecc_gf2m_pkg::NREG,
    parameter int CW     = ecc_gf2m_pkg::CW
) (
    input logic              clk,
    input logic              rst,
    gf2m_sqr_regbank_if.slave bus
);
    import ecc_gf2m_pkg::*;

    localparam int DW = (NREG > 1) ? $clog2(NREG) : 1;

    state_t                     r_state;
    logic                       r_ready;
    logic                       r_done;
    logic                       r_err;
    logic [M-1:0]               r_work;
    logic [CW-1:0]              r_cnt;
    logic [DW-1:0]              r_dst;
    logic [NREG-1:0][M-1:0]     r_regs;
    logic [M-1:0]               w_sqr;
    logic [M-1:0]               w_wdata;
    logic                       w_hit;

    gf2m_square_trinomial #(
        .M      (M),
        .POLY_K (POLY_K)
    ) u_sqr (
        .DIN  (r_work),
        .DOUT (w_sqr)
    );

    assign w_hit = int'(r_dst) < NREG;

`ifdef GF2M_SQR_ACC_EN
    logic r_acc;
    assign w_wdata = r_acc ? (r_regs[r_dst] ^ r_work) : r_work;
`else
    assign w_wdata = r_work;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_dst   <= '0;
            r_regs  <= '0;
`ifdef GF2M_SQR_ACC_EN
            r_acc   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_work  <= bus.src_sel ? bus.B : bus.A;
                        r_cnt   <= bus.sqr_cnt;
                        r_dst   <= bus.dst;
                        r_ready <= 1'b0;
`ifdef GF2M_SQR_ACC_EN
                        r_acc   <= bus.acc;
`endif
                        r_state <= (bus.sqr_cnt != '0) ? RUN : WRITE;
                    end
                end
                RUN: begin
                    r_work <= w_sqr;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    // Out-of-range destinations still complete, flagged by err.
                    if (w_hit) begin
                        r_regs[r_dst] <= w_wdata;
                    end
                    r_done  <= 1'b1;
                    r_err   <= ~w_hit;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.regs_q = r_regs;

endmodule
